// File: rtl/dma_stream_ctrl_if.sv
// AXI-Stream link from the DMA streaming controller to the PL DMA engine.
interface dma_stream_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   m_tdata;
    logic [DATA_W/8-1:0] m_tkeep;
    logic                m_tlast;
    logic                m_tvalid;
    logic                m_tready;

    modport master (output m_tdata, m_tkeep, m_tlast, m_tvalid, input m_tready);
    modport slave  (input m_tdata, m_tkeep, m_tlast, m_tvalid, output m_tready);
endinterface

// File: rtl/dma_stream_ctrl.sv
// DMA streaming controller: buffers wide CPU-side words in a FIFO, splits each
// into DATA_W-bit beats LSB-first and emits framed AXI-Stream packets
// (pad preamble, payload, TLAST) with clean abort framing and status counters.
module dma_stream_ctrl #(
    parameter int                DATA_W         = 32,
    parameter int                RATIO          = 4,
    parameter int                DEPTH_LOG2     = 4,
    parameter int                CNT_W          = 16,
    parameter int                PREAMBLE_BEATS = 8,
    parameter logic [DATA_W-1:0] PAD_WORD       = 32'hFEFEFEFE
) (
    input  logic                    pl_clk,
    input  logic                    nreset,
    input  logic                    fifo_reset,
    input  logic                    dma_start,
    input  logic [CNT_W-1:0]        pkt_len,
    input  logic [DATA_W*RATIO-1:0] dma_in,
    input  logic                    dma_we,
    output logic                    dma_writable,
    dma_stream_ctrl_if.master       axis,
    output logic [DEPTH_LOG2:0]     fifo_level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        beats_sent,
    output logic [2:0]              state
);

    localparam int IN_W  = DATA_W * RATIO;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [IN_W-1:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]        wr_ptr;
    logic [DEPTH_LOG2-1:0]        rd_ptr;
    logic [DEPTH_LOG2:0]          level_q;
    logic                         overflow_q;
    logic                         full;
    logic                         empty;
    logic                         wr_en;
    logic                         pop;
    logic [RATIO-1:0][DATA_W-1:0] head_beats;

    // Packet control
    state_t                       state_q;
    state_t                       state_d;
    logic [CNT_W-1:0]             len_q;
    logic [CNT_W-1:0]             loaded_cnt;
    logic [CNT_W-1:0]             pre_cnt;
    logic [CNT_W-1:0]             sent_q;
    logic [SUB_W-1:0]             sub_idx;

    // Output register and next-beat controls
    logic                         out_valid;
    logic                         out_last;
    logic                         out_payload;
    logic [DATA_W-1:0]            out_data;
    logic                         ld;
    logic [DATA_W-1:0]            ld_data;
    logic                         ld_last;
    logic                         ld_payload;
    logic                         start_pkt;
    logic                         enter_abort;
    logic                         slot_free;
    logic                         tail_pending;
    logic                         abort_req;

    // Full is judged before any pop in the same cycle, so a write into a full
    // FIFO is dropped even when the reader frees a slot on that edge.
    assign full       = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty      = (level_q == '0);
    assign wr_en      = dma_we && !full && !fifo_reset;
    assign head_beats = mem[rd_ptr];

    // The output slot can take a new beat when empty or being handshaken now.
    assign slot_free    = !out_valid || axis.m_tready;
    assign tail_pending = out_valid && out_last;
    assign abort_req    = !dma_start || fifo_reset;

    // Next-state and beat-load decisions
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        ld          = 1'b0;
        ld_data     = PAD_WORD;
        ld_last     = 1'b0;
        ld_payload  = 1'b0;
        pop         = 1'b0;
        start_pkt   = 1'b0;
        enter_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_start && !empty && !fifo_reset) begin
                    start_pkt = 1'b1;
                    state_d   = (PREAMBLE_BEATS == 0) ? DATA : PRE;
                end
            end
            PRE: begin
                if (abort_req) begin
                    state_d     = ABORT;
                    enter_abort = 1'b1;
                end else if (slot_free) begin
                    ld = 1'b1;
                    if (pre_cnt == CNT_W'(PREAMBLE_BEATS - 1)) state_d = DATA;
                end
            end
            DATA: begin
                // A loaded TLAST beat always finishes the packet normally.
                if (tail_pending) begin
                    if (axis.m_tready) state_d = DONE;
                end else if (abort_req) begin
                    state_d     = ABORT;
                    enter_abort = 1'b1;
                end else if (slot_free && !empty) begin
                    ld         = 1'b1;
                    ld_data    = head_beats[sub_idx];
                    ld_payload = 1'b1;
                    ld_last    = (loaded_cnt == len_q - CNT_W'(1));
                    pop        = (sub_idx == SUB_W'(RATIO - 1));
                end
            end
            ABORT: begin
                if (tail_pending) begin
                    if (axis.m_tready) state_d = DONE;
                end else if (slot_free) begin
                    ld      = 1'b1;
                    ld_last = 1'b1;
                end
            end
            DONE: begin
                if (!dma_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge pl_clk or negedge nreset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Packet length, preamble/payload counters and sub-beat index
    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            len_q      <= '0;
            loaded_cnt <= '0;
            pre_cnt    <= '0;
            sent_q     <= '0;
            sub_idx    <= '0;
        end else begin
            if (start_pkt) begin
                len_q      <= pkt_len;
                loaded_cnt <= '0;
                pre_cnt    <= '0;
                sent_q     <= '0;
            end else begin
                if (ld && state_q == PRE) pre_cnt <= pre_cnt + CNT_W'(1);
                if (ld && ld_payload) loaded_cnt <= loaded_cnt + CNT_W'(1);
                if (out_valid && axis.m_tready && out_payload) sent_q <= sent_q + CNT_W'(1);
            end
            // An aborted word restarts from its first beat on the next packet.
            if (start_pkt || enter_abort || fifo_reset) sub_idx <= '0;
            else if (ld && ld_payload) sub_idx <= pop ? '0 : sub_idx + SUB_W'(1);
        end
    end

    // Registered AXI-Stream output; held while valid and not accepted
    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_payload <= 1'b0;
            out_data    <= PAD_WORD;
        end else if (ld) begin
            out_valid   <= 1'b1;
            out_last    <= ld_last;
            out_payload <= ld_payload;
            out_data    <= ld_data;
        end else if (out_valid && axis.m_tready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_payload <= 1'b0;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge pl_clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (fifo_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level_q <= level_q + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(pop);
            if (dma_we && full) overflow_q <= 1'b1;
        end
    end

    // FIFO word storage
    always_ff @(posedge pl_clk) begin
        // NOTE: the storage array has no reset; occupancy tracking guarantees
        // no slot is read before it has been written.
        if (wr_en) mem[wr_ptr] <= dma_in;
    end

    assign axis.m_tdata  = out_data;
    assign axis.m_tkeep  = '1;
    assign axis.m_tlast  = out_last;
    assign axis.m_tvalid = out_valid;
    assign dma_writable  = !full;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;
    assign beats_sent    = sent_q;
    assign state         = state_q;

endmodule

// File: tb/tb_dma_stream_ctrl.sv
// Directed self-checking bench for dma_stream_ctrl: framing, backpressure,
// underrun, abort/replay, overflow and asynchronous reset mid-packet.
module tb_dma_stream_ctrl;

    localparam int           DATA_W     = 32;
    localparam int           RATIO      = 4;
    localparam int           DEPTH_LOG2 = 4;
    localparam int           CNT_W      = 16;
    localparam logic [31:0]  PAD        = 32'hFEFEFEFE;
    localparam logic [127:0] W0         = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] W1         = 128'h88888888_77777777_66666666_55555555;
    localparam logic [127:0] W2         = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;

    logic                  pl_clk     = 1'b0;
    logic                  nreset     = 1'b0;
    logic                  fifo_reset = 1'b0;
    logic                  dma_start  = 1'b0;
    logic [CNT_W-1:0]      pkt_len    = 16'd8;
    logic [127:0]          dma_in     = '0;
    logic                  dma_we     = 1'b0;
    logic                  dma_writable;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic                  overflow;
    logic [CNT_W-1:0]      beats_sent;
    logic [2:0]            state;

    dma_stream_ctrl_if #(.DATA_W(DATA_W)) axis ();

    dma_stream_ctrl #(
        .DATA_W(DATA_W), .RATIO(RATIO), .DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W),
        .PREAMBLE_BEATS(8), .PAD_WORD(PAD)
    ) dut (
        .pl_clk(pl_clk), .nreset(nreset), .fifo_reset(fifo_reset),
        .dma_start(dma_start), .pkt_len(pkt_len), .dma_in(dma_in), .dma_we(dma_we),
        .dma_writable(dma_writable), .axis(axis), .fifo_level(fifo_level),
        .overflow(overflow), .beats_sent(beats_sent), .state(state)
    );

    always #5 pl_clk = ~pl_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] got_data [$];
    bit          got_last [$];
    logic [31:0] exp_data [$];
    bit          exp_last [$];
    bit          seen_last;
    int          cyc_used;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge pl_clk);
    endtask

    task automatic write_word(input logic [127:0] w);
        dma_in = w;
        dma_we = 1'b1;
        step();
        dma_we = 1'b0;
    endtask

    task automatic clear_all();
        exp_data.delete();
        exp_last.delete();
        got_data.delete();
        got_last.delete();
    endtask

    task automatic exp_pads(input int n);
        repeat (n) begin
            exp_data.push_back(PAD);
            exp_last.push_back(1'b0);
        end
    endtask

    task automatic exp_word(input logic [127:0] w);
        for (int k = 0; k < RATIO; k++) begin
            exp_data.push_back(w[k*32 +: 32]);
            exp_last.push_back(1'b0);
        end
    endtask

    task automatic exp_mark_last();
        exp_last[exp_last.size()-1] = 1'b1;
    endtask

    // Records handshaken beats; returns (without advancing) on a TLAST
    // handshake or once stop_beats beats are held. Checks AXI hold on stalls.
    task automatic capture(input int cycles, input int stop_beats, input bit rand_ready);
        bit          stall;
        logic [31:0] hd;
        bit          hl;
        stall     = 1'b0;
        hd        = '0;
        hl        = 1'b0;
        seen_last = 1'b0;
        cyc_used  = cycles;
        for (int c = 0; c < cycles; c++) begin
            axis.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                check("hold_valid", axis.m_tvalid, 1);
                check("hold_data", axis.m_tdata, hd);
                check("hold_last", axis.m_tlast, hl);
            end
            stall = axis.m_tvalid && !axis.m_tready;
            hd    = axis.m_tdata;
            hl    = axis.m_tlast;
            if (axis.m_tvalid && axis.m_tready) begin
                got_data.push_back(axis.m_tdata);
                got_last.push_back(axis.m_tlast);
                if (axis.m_tlast || got_data.size() >= stop_beats) begin
                    seen_last = axis.m_tlast;
                    cyc_used  = c + 1;
                    return;
                end
            end
            step();
        end
    endtask

    task automatic check_packet(input string tag);
        check({tag, "_len"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axis.m_tready = 1'b1;
        repeat (3) step();

        // Reset state while nreset is held low
        check("rst_tvalid", axis.m_tvalid, 0);
        check("rst_tlast", axis.m_tlast, 0);
        check("rst_tdata", axis.m_tdata, PAD);
        check("rst_tkeep", axis.m_tkeep, 4'hF);
        check("rst_level", fifo_level, 0);
        check("rst_writable", dma_writable, 1);
        check("rst_overflow", overflow, 0);
        check("rst_sent", beats_sent, 0);
        check("rst_state", state, 0);
        nreset = 1'b1;
        step();

        // Basic packet at full rate
        clear_all();
        write_word(W0);
        write_word(W1);
        check("basic_level", fifo_level, 2);
        dma_start = 1'b1;
        step();
        check("start_state", state, 1);
        check("start_tvalid", axis.m_tvalid, 0);
        capture(60, 1000, 1'b0);
        exp_pads(8); exp_word(W0); exp_word(W1); exp_mark_last();
        check_packet("basic");
        check("basic_seen_last", seen_last, 1);
        check("basic_cycles", cyc_used, 17);
        step();
        check("basic_state_done", state, 4);
        check("basic_sent", beats_sent, 8);
        check("basic_level_end", fifo_level, 0);
        check("basic_tvalid_end", axis.m_tvalid, 0);
        dma_start = 1'b0;
        step();
        check("basic_state_idle", state, 0);

        // Same packet under random backpressure
        clear_all();
        write_word(W0);
        write_word(W1);
        dma_start = 1'b1;
        step();
        capture(400, 1000, 1'b1);
        exp_pads(8); exp_word(W0); exp_word(W1); exp_mark_last();
        check_packet("bp");
        check("bp_seen_last", seen_last, 1);
        step();
        check("bp_state_done", state, 4);
        check("bp_sent", beats_sent, 8);
        dma_start = 1'b0;
        axis.m_tready = 1'b1;
        step();

        // Underrun: one word, long gap, then the second word
        clear_all();
        write_word(W0);
        dma_start = 1'b1;
        step();
        capture(40, 1000, 1'b0);
        check("ur_gap_beats", got_data.size(), 12);
        check("ur_gap_no_last", seen_last, 0);
        check("ur_gap_tvalid", axis.m_tvalid, 0);
        check("ur_gap_state", state, 2);
        check("ur_gap_sent", beats_sent, 4);
        write_word(W1);
        capture(20, 1000, 1'b0);
        exp_pads(8); exp_word(W0); exp_word(W1); exp_mark_last();
        check_packet("underrun");
        check("ur_seen_last", seen_last, 1);
        step();
        check("ur_sent", beats_sent, 8);
        dma_start = 1'b0;
        step();
        check("ur_state_idle", state, 0);

        // Abort after three payload beats, then replay the partial word
        clear_all();
        write_word(W0);
        write_word(W1);
        dma_start = 1'b1;
        step();
        capture(40, 11, 1'b0);
        check("ab_beats_before", got_data.size(), 11);
        dma_start = 1'b0;
        step();
        capture(10, 1000, 1'b0);
        exp_pads(8);
        exp_data.push_back(32'h11111111); exp_last.push_back(1'b0);
        exp_data.push_back(32'h22222222); exp_last.push_back(1'b0);
        exp_data.push_back(32'h33333333); exp_last.push_back(1'b0);
        exp_data.push_back(PAD);          exp_last.push_back(1'b1);
        check_packet("abort");
        step();
        check("ab_state_done", state, 4);
        check("ab_sent", beats_sent, 3);
        check("ab_level", fifo_level, 2);
        step();
        check("ab_state_idle", state, 0);

        clear_all();
        dma_start = 1'b1;
        step();
        capture(60, 1000, 1'b0);
        exp_pads(8); exp_word(W0); exp_word(W1); exp_mark_last();
        check_packet("replay");
        step();
        check("replay_level", fifo_level, 0);
        dma_start = 1'b0;
        step();

        // Overflow and flush
        for (int i = 0; i < 16; i++) write_word(128'(i + 1));
        check("ovf_level_full", fifo_level, 16);
        check("ovf_writable_full", dma_writable, 0);
        check("ovf_flag_before", overflow, 0);
        write_word(W2);
        check("ovf_flag_set", overflow, 1);
        check("ovf_level_kept", fifo_level, 16);
        fifo_reset = 1'b1;
        step();
        fifo_reset = 1'b0;
        check("flush_level", fifo_level, 0);
        check("flush_overflow", overflow, 0);
        check("flush_writable", dma_writable, 1);

        // Asynchronous reset while the TLAST beat is stalled on the bus
        clear_all();
        write_word(W0);
        write_word(W1);
        write_word(W2);
        dma_start = 1'b1;
        step();
        capture(40, 15, 1'b0);
        step();
        axis.m_tready = 1'b0;
        step();
        check("mid_pre_tvalid", axis.m_tvalid, 1);
        check("mid_pre_tlast", axis.m_tlast, 1);
        check("mid_pre_tdata", axis.m_tdata, 32'h88888888);
        check("mid_pre_level", fifo_level, 1);
        nreset = 1'b0;
        #1;
        check("mid_rst_tvalid", axis.m_tvalid, 0);
        check("mid_rst_tlast", axis.m_tlast, 0);
        check("mid_rst_tdata", axis.m_tdata, PAD);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_sent", beats_sent, 0);
        step();
        dma_start     = 1'b0;
        axis.m_tready = 1'b1;
        nreset        = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_stream_ctrl.md
# dma_stream_ctrl

Parametrised single-clock DMA streaming controller: accepts wide words from the CPU-side write port into an internal FIFO, serialises each into DATA_W-bit beats, and emits framed packets on an AXI-Stream master (pad preamble, payload, TLAST). It sits between the core's DMA write port and the PL DMA engine. It adds over the previous generation: configurable widths and depth, runtime packet length, full AXI hold semantics, clean abort framing, overflow detection and status counters.

## Interface
- DATA_W, 32: output beat width (bits).
- RATIO, 4: beats per input word; input width IN_W = DATA_W*RATIO.
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 input words.
- CNT_W, 16: width of pkt_len and beat counters.
- PREAMBLE_BEATS, 8: pad beats before payload (0 = none).
- PAD_WORD, 32'hFEFEFEFE: data value of preamble/abort beats.
- pl_clk  in  1  sole clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- fifo_reset  in  1  synchronous flush (FIFO, overflow flag, abort any packet).
- dma_start  in  1  level: packet enable.
- pkt_len  in  CNT_W  payload beats per packet; 0 means 2^CNT_W; sampled at packet start.
- dma_in  in  IN_W  write data.
- dma_we  in  1  write strobe.
- dma_writable  out  1  FIFO not full (combinational from occupancy).
- m_tdata  out  DATA_W  stream data (registered).
- m_tkeep  out  DATA_W/8  all ones.
- m_tlast  out  1  last beat of packet (registered).
- m_tvalid  out  1  beat valid (registered).
- m_tready  in  1  sink ready.
- fifo_level  out  DEPTH_LOG2+1  input words stored.
- overflow  out  1  sticky: write attempted while full.
- beats_sent  out  CNT_W  payload beats handshaken in current/last packet.
- state  out  3  FSM state encoding.

## Operation
- Write: dma_we && !full stores dma_in. dma_we while full: word dropped, overflow<=1. overflow cleared only by reset or fifo_reset.
- Read: head word split LSB-first: beat k = dma_in[k*DATA_W +: DATA_W], k=0..RATIO-1; word popped after beat RATIO-1 is loaded into the output register.
- Simultaneous write and pop: both occur; level unchanged. Write to full FIFO in the same cycle as pop is still dropped (full evaluated before pop).
- FSM states: IDLE(0), PRE(1), DATA(2), ABORT(3), DONE(4).
- IDLE: tvalid=0. dma_start && level>0 -> load pkt_len, clear beats_sent, go PRE (or DATA if PREAMBLE_BEATS=0).
- PRE: present PAD_WORD, tlast=0, for PREAMBLE_BEATS handshakes, then DATA.
- DATA: present FIFO beats; beats_sent increments per handshake. FIFO empty with packet incomplete: tvalid drops (stall), no TLAST. Beat number pkt_len carries tlast=1; its handshake -> DONE.
- Abort: dma_start low in PRE or DATA. Any beat with tvalid=1 completes unchanged; next go ABORT: present one PAD_WORD beat with tlast=1; on handshake -> DONE. Partially consumed input word stays at FIFO head, sub-beat index reset to 0. fifo_reset in PRE/DATA: FIFO emptied immediately, then same abort path.
- DONE: tvalid=0; dma_start low -> IDLE. No new packet while dma_start held.
- AXI rule: once tvalid=1, tdata/tlast stay stable until m_tready=1.

## Timing
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=PAD_WORD, fifo empty, dma_writable=1, overflow=0, beats_sent=0, state=IDLE.
- Start latency: condition sampled at edge N -> tvalid=1 after edge N+1.
- Throughput: one beat per cycle while m_tready=1 and data available; no bubble at word boundaries or PRE->DATA.
- Write at edge N visible in fifo_level and to the reader after edge N.
- beats_sent saturates never; wraps mod 2^CNT_W (only reachable with pkt_len=0).
- nreset assertion mid-packet: all state cleared asynchronously; stream drops without TLAST.

## Test plan
- Basic: pkt_len=8, write 2 words 0x4..._3..._2..._1..., ready=1 -> 8 PAD_WORD beats then beats 0x1,0x2,0x3,0x4,... tlast on 8th payload beat; DONE; beats_sent=8.
- Backpressure: toggle m_tready randomly -> tdata/tlast never change while valid&&!ready; same sequence as basic.
- Underrun: pkt_len=8, write 1 word, wait 20 cycles, write 1 word -> tvalid low during gap, no early tlast, packet completes with 8 payload beats.
- Abort: drop dma_start after 3 payload beats -> in-flight beat completes, one PAD_WORD beat with tlast=1, state DONE->IDLE; remaining word replays from beat 0 next packet.
- Overflow: fill 16 words (DEPTH_LOG2=4), dma_writable=0, write 17th -> dropped, overflow=1, level=16; fifo_reset -> level=0, overflow=0.
- Reset mid-packet: assert nreset during DATA -> tvalid=0, tlast=0 immediately, level=0, state=IDLE.
